// File: rtl/cpu_types_pkg.sv
// Shared CPU types: request-unit channel state and the latched data request.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RU_IDLE   = 2'd0,
    RU_DPEND  = 2'd1,
    RU_HALTED = 2'd2
  } ru_state_t;

  // One outstanding data access, plus a halt that must take effect once it completes.
  typedef struct packed {
    logic halt;
    logic wen;
    logic ren;
  } ru_req_t;

endpackage

// File: rtl/request_unit_mc_if.sv
// Bundle of request_unit_mc signals; the `ru` modport faces the block, `tb` drives it.
// timeout_err exists only when RU_TIMEOUT_EN is defined.
interface request_unit_mc_if #(
  parameter int unsigned CORES = 2
) (
  input logic CLK
);
  logic             RST;
  logic [CORES-1:0] ihit;
  logic [CORES-1:0] dhit;
  logic [CORES-1:0] iREN;
  logic [CORES-1:0] dREN;
  logic [CORES-1:0] dWEN;
  logic [CORES-1:0] halt;
  logic [CORES-1:0] imemREN;
  logic [CORES-1:0] dmemREN;
  logic [CORES-1:0] dmemWEN;
  logic [CORES-1:0] PC_WEN;
`ifdef RU_TIMEOUT_EN
  logic [CORES-1:0] timeout_err;

  modport ru (input CLK, RST, ihit, dhit, iREN, dREN, dWEN, halt,
              output imemREN, dmemREN, dmemWEN, PC_WEN, timeout_err);
  modport tb (input CLK, imemREN, dmemREN, dmemWEN, PC_WEN, timeout_err,
              output RST, ihit, dhit, iREN, dREN, dWEN, halt);
`else
  modport ru (input CLK, RST, ihit, dhit, iREN, dREN, dWEN, halt,
              output imemREN, dmemREN, dmemWEN, PC_WEN);
  modport tb (input CLK, imemREN, dmemREN, dmemWEN, PC_WEN,
              output RST, ihit, dhit, iREN, dREN, dWEN, halt);
`endif
endinterface

// File: rtl/ru_channel.sv
// One request-unit channel: FSM, latched data request, PC_WEN and optional watchdog.
// Watchdog and timeout_err port are built only when RU_TIMEOUT_EN is defined.
module ru_channel
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic ihit,
  input  logic dhit,
  input  logic iREN,
  input  logic dREN,
  input  logic dWEN,
  input  logic halt,
  output logic imemREN,
  output logic dmemREN,
  output logic dmemWEN,
  output logic PC_WEN
`ifdef RU_TIMEOUT_EN
  ,
  output logic timeout_err
`endif
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("ru_channel: TIMEOUT out of range");
  end

  ru_state_t state_q, state_d;
  ru_req_t   req_q, req_d;
  logic      imem_c, dren_c, dwen_c, pc_wen_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RU_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    imem_c   = 1'b0;
    dren_c   = 1'b0;
    dwen_c   = 1'b0;
    pc_wen_c = 1'b0;
    case (state_q)
      RU_IDLE: begin
        imem_c   = iREN;
        pc_wen_c = ihit & ~dREN & ~dWEN & ~halt;
        if (ihit && (dREN || dWEN)) begin
          // A combined read+write request is treated as a write.
          state_d    = RU_DPEND;
          req_d.wen  = dWEN;
          req_d.ren  = dREN & ~dWEN;
          req_d.halt = halt;
        end else if (halt && !(dREN || dWEN)) begin
          state_d = RU_HALTED;
        end
      end
      RU_DPEND: begin
        dren_c = req_q.ren;
        dwen_c = req_q.wen;
        if (dhit) begin
          pc_wen_c = ~req_q.halt;
          req_d    = '0;
          state_d  = (req_q.halt || halt) ? RU_HALTED : RU_IDLE;
        end
      end
      RU_HALTED: ;
      default: state_d = RU_IDLE;
    endcase
  end

  // Reset cycles blank every output, even before the reset edge lands.
  assign imemREN = imem_c & ~RST;
  assign dmemREN = dren_c & ~RST;
  assign dmemWEN = dwen_c & ~RST;
  assign PC_WEN  = pc_wen_c & ~RST;

`ifdef RU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Counter idles at zero so each pending phase starts fresh; saturates at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q != RU_DPEND) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) err_d = 1'b1;
    end
  end

  assign timeout_err = err_q & ~RST;
`endif

endmodule

// File: rtl/request_unit_mc.sv
// Multi-channel request unit: CORES independent ru_channel instances.
// Defining RU_TIMEOUT_EN adds the per-channel stall watchdog and timeout_err.
module request_unit_mc #(
  parameter int unsigned CORES   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CORES-1:0] ihit,
  input  logic [CORES-1:0] dhit,
  input  logic [CORES-1:0] iREN,
  input  logic [CORES-1:0] dREN,
  input  logic [CORES-1:0] dWEN,
  input  logic [CORES-1:0] halt,
  output logic [CORES-1:0] imemREN,
  output logic [CORES-1:0] dmemREN,
  output logic [CORES-1:0] dmemWEN,
  output logic [CORES-1:0] PC_WEN
`ifdef RU_TIMEOUT_EN
  ,
  output logic [CORES-1:0] timeout_err
`endif
);

  if (CORES < 1 || CORES > 4) begin : g_bad_cores
    $error("request_unit_mc: CORES must be 1..4");
  end

  for (genvar i = 0; i < CORES; i++) begin : g_ch
    ru_channel #(
      .TIMEOUT(TIMEOUT)
    ) u_ch (
      .CLK        (CLK),
      .RST        (RST),
      .ihit       (ihit[i]),
      .dhit       (dhit[i]),
      .iREN       (iREN[i]),
      .dREN       (dREN[i]),
      .dWEN       (dWEN[i]),
      .halt       (halt[i]),
      .imemREN    (imemREN[i]),
      .dmemREN    (dmemREN[i]),
      .dmemWEN    (dmemWEN[i]),
      .PC_WEN     (PC_WEN[i])
`ifdef RU_TIMEOUT_EN
      ,
      .timeout_err(timeout_err[i])
`endif
    );
  end

endmodule

// File: tb/tb_request_unit_mc.sv
// Directed bench for request_unit_mc (CORES=2); watchdog scenario runs when RU_TIMEOUT_EN is defined.
module tb_request_unit_mc;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] ihit, dhit, iREN, dREN, dWEN, halt;
  logic [1:0] imemREN, dmemREN, dmemWEN, PC_WEN;
`ifdef RU_TIMEOUT_EN
  logic [1:0] timeout_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  request_unit_mc #(
    .CORES  (2),
    .TIMEOUT(8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ihit       (ihit),
    .dhit       (dhit),
    .iREN       (iREN),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .halt       (halt),
    .imemREN    (imemREN),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .PC_WEN     (PC_WEN)
`ifdef RU_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; iREN = 2'b11; ihit = 2'b11; dhit = 2'b11;
    dREN = 2'b11; dWEN = 2'b00; halt = 2'b00;
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      n_checks++;
      if ({imemREN, dmemREN, dmemWEN, PC_WEN} !== 8'h00)
        $display("FAIL reset_outs cyc%0d: got %h want 00", k, {imemREN, dmemREN, dmemWEN, PC_WEN});
      else n_pass++;
`ifdef RU_TIMEOUT_EN
      n_checks++;
      if (timeout_err !== 2'b00) $display("FAIL reset_terr: got %b want 00", timeout_err);
      else n_pass++;
`endif
    end
    next_cycle();
    RST = 1'b0; ihit = 2'b00; dhit = 2'b00; dREN = 2'b00; #1;
    n_checks++;
    if (imemREN !== 2'b11) $display("FAIL reset_release_imem: got %b want 11", imemREN);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [1:0] exp_pc;
    next_cycle();
    iREN = 2'b11; ihit = 2'b11; dREN = 2'b01; #1;
    n_checks++;
    if (PC_WEN !== 2'b10) $display("FAIL load_issue_pc: got %b want 10", PC_WEN);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      dhit = (k == 4) ? 2'b01 : 2'b00; #1;
      exp_pc = (k == 4) ? 2'b11 : 2'b10;
      n_checks++;
      if (dmemREN !== 2'b01) $display("FAIL load_dren cyc%0d: got %b want 01", k, dmemREN);
      else n_pass++;
      n_checks++;
      if (imemREN !== 2'b10) $display("FAIL load_imem cyc%0d: got %b want 10", k, imemREN);
      else n_pass++;
      n_checks++;
      if (PC_WEN !== exp_pc) $display("FAIL load_pc cyc%0d: got %b want %b", k, PC_WEN, exp_pc);
      else n_pass++;
    end
    next_cycle();
    dhit = 2'b00; dREN = 2'b00; ihit = 2'b10; #1;
    n_checks++;
    if ({dmemREN, imemREN, PC_WEN} !== 6'b00_11_10)
      $display("FAIL load_done: got %b want 001110", {dmemREN, imemREN, PC_WEN});
    else n_pass++;
  endtask

  task automatic test_store_priority();
    next_cycle();
    ihit = 2'b11; dREN = 2'b01; dWEN = 2'b01; #1;
    n_checks++;
    if ({dmemWEN, PC_WEN} !== 4'b00_10) $display("FAIL store_issue: got %b want 0010", {dmemWEN, PC_WEN});
    else n_pass++;
    next_cycle();
    dhit = 2'b01; #1;
    n_checks++;
    if ({dmemWEN, dmemREN, PC_WEN} !== 6'b01_00_11)
      $display("FAIL store_pulse: got %b want 010011", {dmemWEN, dmemREN, PC_WEN});
    else n_pass++;
    next_cycle();
    dhit = 2'b00; dREN = 2'b00; dWEN = 2'b00; ihit = 2'b10; #1;
    n_checks++;
    if ({dmemWEN, imemREN} !== 4'b00_11) $display("FAIL store_end: got %b want 0011", {dmemWEN, imemREN});
    else n_pass++;
  endtask

  task automatic test_halt();
    next_cycle();
    ihit = 2'b11; dWEN = 2'b01; halt = 2'b01; #1;
    n_checks++;
    if (PC_WEN !== 2'b10) $display("FAIL halt_issue_pc: got %b want 10", PC_WEN);
    else n_pass++;
    next_cycle();
    ihit = 2'b10; #1;
    n_checks++;
    if ({dmemWEN, imemREN} !== 4'b01_10) $display("FAIL halt_store: got %b want 0110", {dmemWEN, imemREN});
    else n_pass++;
    next_cycle();
    dhit = 2'b01; #1;
    n_checks++;
    if (dmemWEN !== 2'b01) $display("FAIL halt_store_hit: got %b want 01", dmemWEN);
    else n_pass++;
    for (int k = 0; k < 22; k++) begin
      next_cycle();
      halt = 2'b00; iREN = 2'b11; ihit = 2'b11;
      dhit = (k % 2 == 1) ? 2'b01 : 2'b00;
      dWEN = (k % 3 == 0) ? 2'b01 : 2'b00; #1;
      n_checks++;
      if ({imemREN[0], dmemREN[0], dmemWEN[0], PC_WEN[0]} !== 4'b0000)
        $display("FAIL halted_ch0 cyc%0d: got %b want 0000", k, {imemREN[0], dmemREN[0], dmemWEN[0], PC_WEN[0]});
      else n_pass++;
      n_checks++;
      if (PC_WEN[1] !== 1'b1) $display("FAIL halted_ch1_pc cyc%0d: got %b want 1", k, PC_WEN[1]);
      else n_pass++;
    end
    next_cycle();
    RST = 1'b1; dWEN = 2'b00; dhit = 2'b00; #1;
    n_checks++;
    if ({imemREN, PC_WEN} !== 4'b0000) $display("FAIL halt_rst: got %b want 0000", {imemREN, PC_WEN});
    else n_pass++;
    next_cycle();
    RST = 1'b0; #1;
    n_checks++;
    if ({imemREN, PC_WEN} !== 4'b11_11) $display("FAIL halt_resume: got %b want 1111", {imemREN, PC_WEN});
    else n_pass++;
  endtask

  task automatic test_rst_mid_pend();
    next_cycle();
    ihit = 2'b11; dREN = 2'b01; #1;
    next_cycle();
    ihit = 2'b10; #1;
    n_checks++;
    if (dmemREN !== 2'b01) $display("FAIL rstmid_pend: got %b want 01", dmemREN);
    else n_pass++;
    next_cycle();
    RST = 1'b1; #1;
    n_checks++;
    if (dmemREN !== 2'b00) $display("FAIL rstmid_during: got %b want 00", dmemREN);
    else n_pass++;
    next_cycle();
    RST = 1'b0; dhit = 2'b01; #1;
    n_checks++;
    if ({dmemREN, PC_WEN} !== 4'b00_10) $display("FAIL rstmid_after: got %b want 0010", {dmemREN, PC_WEN});
    else n_pass++;
    next_cycle();
    dhit = 2'b00; dREN = 2'b00; #1;
  endtask

`ifdef RU_TIMEOUT_EN
  task automatic test_timeout();
    next_cycle();
    ihit = 2'b11; dREN = 2'b01; #1;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      ihit = 2'b10; #1;
      n_checks++;
      if ({dmemREN, timeout_err} !== 4'b01_00)
        $display("FAIL wd_pending cyc%0d: got %b want 0100", k, {dmemREN, timeout_err});
      else n_pass++;
    end
    next_cycle(); #1;
    n_checks++;
    if ({dmemREN, timeout_err} !== 4'b01_01) $display("FAIL wd_fire: got %b want 0101", {dmemREN, timeout_err});
    else n_pass++;
    next_cycle();
    dhit = 2'b01; #1;
    n_checks++;
    if (PC_WEN !== 2'b11) $display("FAIL wd_late_hit_pc: got %b want 11", PC_WEN);
    else n_pass++;
    next_cycle();
    dhit = 2'b00; dREN = 2'b00; #1;
    n_checks++;
    if ({timeout_err, dmemREN, imemREN} !== 6'b01_00_11)
      $display("FAIL wd_sticky: got %b want 010011", {timeout_err, dmemREN, imemREN});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store_priority();
    test_halt();
    test_rst_mid_pend();
`ifdef RU_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
